// File: rtl/flash_reader_pkg.sv
// flash_reader_pkg: shared state encoding, data widths and default parameters for the flash sample reader
package flash_reader_pkg;
    localparam int SAMPLE_W        = 16;
    localparam int FLASH_DATA_W    = 32;
    localparam int ADDR_W_DEF      = 23;
    localparam int TIMEOUT_CYC_DEF = 255;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DATA,
        EMIT0,
        EMIT1,
        FINISH
    } state_t;
endpackage

// File: rtl/flash_timeout_ctr.sv
// flash_timeout_ctr: cycle counter that flags expiry after LIMIT counted cycles
// Ports: clk, rst (async, active-high); load clears the count; count advances it;
//        expire is high on the LIMIT-th counted cycle.
module flash_timeout_ctr #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic expire
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            r_cnt <= '0;
        else if (load)
            r_cnt <= '0;
        else if (count)
            r_cnt <= r_cnt + 1'b1;

    // Combinational so the FSM leaves on the LIMIT-th cycle, not one later.
    assign expire = count && (r_cnt == CW'(LIMIT - 1));
endmodule

// File: rtl/flash_sample_reader.sv
// flash_sample_reader: fetch one 32-bit flash word and emit its two 16-bit samples in dir_flag order
// Ports: clk, rst (async, active-high); start/addr/dir_flag request a fetch; busy/done report progress;
//        flash_read/flash_addr/flash_waitrequest/flash_readdatavalid/flash_readdata form the flash master;
//        sample/sample_valid/sample_ready form the sample stream; timeout flags an aborted fetch.
// Build option: FLASH_TIMEOUT_EN adds a fetch timeout of TIMEOUT_CYC cycles.
module flash_sample_reader
    import flash_reader_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       addr,
    input  logic                    dir_flag,
    output logic                    busy,
    output logic                    done,
    output logic                    flash_read,
    output logic [ADDR_W-1:0]       flash_addr,
    input  logic                    flash_waitrequest,
    input  logic                    flash_readdatavalid,
    input  logic [FLASH_DATA_W-1:0] flash_readdata,
    output logic [SAMPLE_W-1:0]     sample,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    timeout
);
    state_t                  r_state, w_next;
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_dir;
    logic [FLASH_DATA_W-1:0] r_data;
    logic                    w_expire;

`ifdef FLASH_TIMEOUT_EN
    logic r_tout;

    flash_timeout_ctr #(.LIMIT(TIMEOUT_CYC)) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .load   (r_state == IDLE),
        .count  (r_state == ISSUE || r_state == WAIT_DATA),
        .expire (w_expire)
    );

    // FINISH is only reachable from the fetch states by expiry, so this is high exactly during an aborted FINISH.
    always_ff @(posedge clk or posedge rst)
        if (rst)
            r_tout <= 1'b0;
        else
            r_tout <= (w_next == FINISH) && (r_state == ISSUE || r_state == WAIT_DATA);

    assign timeout = r_tout;
`else
    logic w_unused_tcyc;
    assign w_unused_tcyc = (TIMEOUT_CYC == 0);
    assign w_expire      = 1'b0;
    assign timeout       = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = start ? ISSUE : IDLE;
            ISSUE:     w_next = w_expire ? FINISH : !flash_waitrequest ? WAIT_DATA : ISSUE;
            WAIT_DATA: w_next = flash_readdatavalid ? EMIT0 : w_expire ? FINISH : WAIT_DATA;
            EMIT0:     w_next = sample_ready ? EMIT1 : EMIT0;
            EMIT1:     w_next = sample_ready ? FINISH : EMIT1;
            FINISH:    w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_dir   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_addr <= addr;
                r_dir  <= dir_flag;
            end
            if (r_state == WAIT_DATA && flash_readdatavalid)
                r_data <= flash_readdata;
        end

    assign busy         = r_state != IDLE;
    assign done         = r_state == FINISH;
    assign flash_read   = r_state == ISSUE;
    assign flash_addr   = r_addr;
    assign sample_valid = r_state == EMIT0 || r_state == EMIT1;
    // The high half goes first when dir is set; EMIT1 always carries the opposite half.
    assign sample = r_state == EMIT0 ? (r_dir ? r_data[31:16] : r_data[15:0]) :
                    r_state == EMIT1 ? (r_dir ? r_data[15:0]  : r_data[31:16]) : '0;
endmodule

// File: tb/tb_flash_sample_reader.sv
// tb_flash_sample_reader: directed stimulus with a queue-based sample/done scoreboard
module tb_flash_sample_reader;
    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0;
    logic [22:0] addr = '0;
    logic        dir_flag = 0;
    logic        busy, done, flash_read, sample_valid, timeout;
    logic [22:0] flash_addr;
    logic        flash_waitrequest = 0;
    logic        flash_readdatavalid = 0;
    logic [31:0] flash_readdata = '0;
    logic [15:0] sample;
    logic        sample_ready = 1;

    int total = 0;
    int bad = 0;
    int cnt = 0;
    logic [15:0] exp_q[$];
    logic        done_q[$];

    flash_sample_reader #(.ADDR_W(23), .TIMEOUT_CYC(8)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .addr                (addr),
        .dir_flag            (dir_flag),
        .busy                (busy),
        .done                (done),
        .flash_read          (flash_read),
        .flash_addr          (flash_addr),
        .flash_waitrequest   (flash_waitrequest),
        .flash_readdatavalid (flash_readdatavalid),
        .flash_readdata      (flash_readdata),
        .sample              (sample),
        .sample_valid        (sample_valid),
        .sample_ready        (sample_ready),
        .timeout             (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cnt++;
    endtask

    always @(negedge clk) begin
        if (!rst && sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_sample: got %h want none", sample);
            end else
                chk("sample", sample, exp_q.pop_front());
        end
        if (!rst && done) begin
            if (done_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_done: got done=1 want none");
            end else
                chk("timeout_with_done", timeout, done_q.pop_front());
        end
        if (!rst && !done && timeout) begin
            total++;
            bad++;
            $display("FAIL timeout_without_done: got timeout=1 want 0");
        end
    end

    task automatic fetch(input logic [22:0] a, input logic d, input logic [31:0] w,
                         input int nwait, input int nlow);
        int t0;
        int n;
        logic [15:0] first;
        logic [15:0] second;
        first  = d ? w[31:16] : w[15:0];
        second = d ? w[15:0]  : w[31:16];
        exp_q.push_back(first);
        exp_q.push_back(second);
        done_q.push_back(1'b0);
        addr = a;
        dir_flag = d;
        start = 1;
        sample_ready = (nlow == 0);
        t0 = cnt;
        cyc();
        start = 0;
        for (int i = 0; i <= nwait; i++) begin
            flash_waitrequest = (i < nwait);
            chk("issue_read", {31'd0, flash_read}, 1);
            chk("issue_addr", {9'd0, flash_addr}, {9'd0, a});
            cyc();
        end
        flash_waitrequest = 0;
        chk("read_dropped", {31'd0, flash_read}, 0);
        cyc();
        flash_readdatavalid = 1;
        flash_readdata = w;
        cyc();
        flash_readdatavalid = 0;
        flash_readdata = 32'hDEAD_0000;
        for (int j = 0; j < nlow; j++) begin
            start = 1;
            addr = ~a;
            chk("stall_sample", {16'd0, sample}, {16'd0, first});
            chk("stall_valid", {31'd0, sample_valid}, 1);
            chk("stall_no_done", {31'd0, done}, 0);
            cyc();
        end
        start = 0;
        sample_ready = 1;
        if (nlow > 0)
            chk("stall_addr", {9'd0, flash_addr}, {9'd0, a});
        n = 0;
        while (!done && n < 20) begin
            cyc();
            n++;
        end
        chk("done_cycle", cnt - t0, 6 + nwait + nlow);
        cyc();
        chk("done_pulse", {31'd0, done}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        #1;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_read", {31'd0, flash_read}, 0);
        chk("rst_valid", {31'd0, sample_valid}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_addr", {9'd0, flash_addr}, 0);
        chk("rst_sample", {16'd0, sample}, 0);
        chk("rst_timeout", {31'd0, timeout}, 0);
        cyc();
        cyc();
        rst = 0;
        cyc();

        fetch(23'h000010, 1'b0, 32'hBEEF1234, 0, 0);
        fetch(23'h000010, 1'b1, 32'hBEEF1234, 0, 0);
        fetch(23'h123456, 1'b0, 32'hCAFE5A5A, 5, 0);
        fetch(23'h7FFFFF, 1'b1, 32'h0F0FA5C3, 0, 4);

        addr = 23'h000055;
        start = 1;
        cyc();
        start = 0;
        cyc();
        chk("mid_busy", {31'd0, busy}, 1);
        rst = 1;
        #1;
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_read", {31'd0, flash_read}, 0);
        chk("arst_addr", {9'd0, flash_addr}, 0);
        chk("arst_valid", {31'd0, sample_valid}, 0);
        chk("arst_sample", {16'd0, sample}, 0);
        chk("arst_done", {31'd0, done}, 0);
        cyc();
        rst = 0;
        flash_readdatavalid = 1;
        flash_readdata = 32'h11112222;
        cyc();
        flash_readdatavalid = 0;
        for (int k = 0; k < 3; k++) begin
            chk("late_busy", {31'd0, busy}, 0);
            chk("late_valid", {31'd0, sample_valid}, 0);
            cyc();
        end

`ifdef FLASH_TIMEOUT_EN
        begin
            int t0;
            int n;
            done_q.push_back(1'b1);
            addr = 23'h000020;
            start = 1;
            t0 = cnt;
            cyc();
            start = 0;
            n = 0;
            while (!done && n < 30) begin
                cyc();
                n++;
            end
            chk("tmo_done_cycle", cnt - t0, 9);
            chk("tmo_flag", {31'd0, timeout}, 1);
            chk("tmo_read_off", {31'd0, flash_read}, 0);
            cyc();
            chk("tmo_pulse", {31'd0, timeout}, 0);
        end
`endif

        fetch(23'h000001, 1'b0, 32'h8000FFFF, 0, 0);
        cyc();
        cyc();
        chk("exp_q_empty", exp_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/flash_sample_reader.md
FLASH_SAMPLE_READER -- requirements
Module: flash_sample_reader

Interface
REQ-001 Parameter ADDR_W, default 23, SHALL set the flash word-address width.
REQ-002 Parameter TIMEOUT_CYC, default 255, SHALL set the timeout limit in cycles (used only with FLASH_TIMEOUT_EN).
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 start  in  1  SHALL request one fetch/emit cycle; sampled only in IDLE.
REQ-006 addr  in  ADDR_W  SHALL be the flash word address from the address generator.
REQ-007 dir_flag  in  1  SHALL select emit order: 0 = low half first, 1 = high half first.
REQ-008 busy  out  1  SHALL be high whenever state is not IDLE.
REQ-009 done  out  1  SHALL be a one-cycle pulse when the cycle completes; it feeds the address generator's step input.
REQ-010 flash_read, flash_addr  out  1/ADDR_W  SHALL be the read request and its address.
REQ-011 flash_waitrequest, flash_readdatavalid  in  1/1  SHALL be the flash slave stall and data-valid signals.
REQ-012 flash_readdata  in  32  SHALL carry two packed 16-bit samples.
REQ-013 sample, sample_valid  out  16/1  SHALL be the audio sample and its valid flag.
REQ-014 sample_ready  in  1  SHALL be the downstream accept signal.
REQ-015 timeout  out  1  SHALL pulse with done on an aborted fetch.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT_DATA, EMIT0, EMIT1 and FINISH; all outputs SHALL be registered or decoded from state.
REQ-017 IDLE: when start=1, the block SHALL latch addr and dir_flag and move to ISSUE; start outside IDLE SHALL be ignored.
REQ-018 ISSUE: flash_read=1 and flash_addr=latched addr; the FSM SHALL hold while waitrequest=1 and SHALL move to WAIT_DATA on the first cycle with waitrequest=0.
REQ-019 readdatavalid SHALL be sampled only in WAIT_DATA, since the slave guarantees at least one cycle of latency.
REQ-020 WAIT_DATA: on readdatavalid=1 the block SHALL capture the 32-bit word and move to EMIT0.
REQ-021 EMIT0: sample = readdata[15:0] if dir=0, else [31:16]; sample_valid=1; the FSM SHALL move to EMIT1 on a cycle with sample_ready=1.
REQ-022 EMIT1: sample SHALL be the other half; on sample_ready=1 the FSM SHALL move to FINISH.
REQ-023 FINISH: done=1 for exactly one cycle, then IDLE; back-to-back start is accepted in the following IDLE cycle.
REQ-024 Minimum latency SHALL be start at cycle 0 -> flash_read at 1 -> data at 3 -> first sample_valid at 4 -> done at 6, given zero wait, valid at the earliest cycle and ready held high.
REQ-025 sample SHALL remain stable while sample_valid=1 and sample_ready=0.

Reset
REQ-026 rst SHALL force IDLE immediately and zero flash_read, flash_addr, sample, sample_valid, done, busy, timeout and all latched registers.
REQ-027 Reset mid-fetch SHALL drop flash_read without waiting for the slave; a late readdatavalid in IDLE SHALL be ignored.

Configuration
REQ-028 With FLASH_TIMEOUT_EN defined, a counter SHALL count cycles in ISSUE+WAIT_DATA; on reaching TIMEOUT_CYC it SHALL drop flash_read, skip EMIT0/EMIT1, enter FINISH, and assert timeout with done.
REQ-029 Without FLASH_TIMEOUT_EN, the block SHALL wait indefinitely and timeout SHALL be tied 0.

Structure
REQ-030 Package flash_reader_pkg SHALL hold the state enum, the SAMPLE_W=16 and FLASH_DATA_W=32 constants, and default parameter values.
REQ-031 Sub-module flash_timeout_ctr (load, count, expire) SHALL be instantiated only under FLASH_TIMEOUT_EN.

Verification
REQ-032 The bench SHALL cover: addr=0x000010, dir=0, no wait, data 0xBEEF1234 -> flash_addr=0x000010; samples 0x1234 then 0xBEEF; done at cycle 6.
REQ-033 The bench SHALL cover: same with dir=1 -> samples 0xBEEF then 0x1234.
REQ-034 The bench SHALL cover: waitrequest high for 5 cycles -> flash_read held 6 cycles; flash_addr stable; a single read accepted.
REQ-035 The bench SHALL cover: sample_ready low for 4 cycles in EMIT0 -> sample is stable, no advance; done only after both halves are accepted.
REQ-036 The bench SHALL cover: rst asserted in WAIT_DATA, then readdatavalid -> outputs 0, state IDLE, no sample_valid.
REQ-037 The bench SHALL cover, with FLASH_TIMEOUT_EN and TIMEOUT_CYC=8, no readdatavalid -> timeout and done pulse together after 8 cycles; no samples emitted.
